// File: rtl/cluster_frame_scheduler_pkg.sv
// Shared constants, header layout, frame record and helpers for the cluster frame scheduler.
package cluster_frame_scheduler_pkg;

  localparam int MXCLUSTERS = 8;
  localparam int MXCLBITS   = 14;
  localparam int MXCNTBITS  = 11;
  localparam int BXMAX      = 3563;
  localparam int BXBITS     = 12;
  localparam int NSBITS     = 4;
  localparam int IDXBITS    = $clog2(MXCLUSTERS);

  localparam int HDR_OVF_BIT   = 13;
  localparam int HDR_NSENT_LSB = 9;
  localparam int HDR_BX_BITS   = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CLU  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BXBITS-1:0]              bx;
    logic                           overflow;
    logic [NSBITS-1:0]              nsent;
    logic [MXCLUSTERS*MXCLBITS-1:0] clusters;
  } frame_t;

  function automatic logic [NSBITS-1:0] clamp_nsent(input logic [MXCNTBITS-1:0] c);
    if (c > MXCNTBITS'(MXCLUSTERS)) return NSBITS'(MXCLUSTERS);
    return c[NSBITS-1:0];
  endfunction

  function automatic logic [MXCLBITS-1:0] make_header(
    input logic                   ovf,
    input logic [NSBITS-1:0]      nsent,
    input logic [HDR_BX_BITS-1:0] bx9
  );
    logic [MXCLBITS-1:0] h;
    h = '0;
    h[HDR_OVF_BIT]                 = ovf;
    h[HDR_NSENT_LSB +: NSBITS]     = nsent;
    h[HDR_BX_BITS-1:0]             = bx9;
    return h;
  endfunction

endpackage

// File: rtl/cluster_frame_scheduler_if.sv
// Output link: a word moves when link_valid && link_ready on a clock edge; while valid is high and
// ready is low the source holds link_data/link_frame stable and keeps valid asserted.
interface cluster_frame_scheduler_if;
  import cluster_frame_scheduler_pkg::*;

  logic [MXCLBITS-1:0] link_data;
  logic                link_valid;
  logic                link_frame;
  logic                link_ready;

  modport master (output link_data, output link_valid, output link_frame, input link_ready);
  modport slave  (input link_data, input link_valid, input link_frame, output link_ready);
endinterface

// File: rtl/cluster_frame_scheduler_buffer.sv
// Two-slot ping-pong frame store: in-order write/read pointers, occupancy flags and a read-word mux.
module cluster_frame_scheduler_buffer
  import cluster_frame_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_req,
  input  frame_t              wr_frame,
  input  logic                rel,
  input  logic                rd_hdr,
  input  logic [IDXBITS-1:0]  rd_idx,
  output logic                wr_accept,
  output logic                head_valid_next,
  output logic [NSBITS-1:0]   rd_nsent,
  output logic [MXCLBITS-1:0] rd_word
);

  frame_t     slot_q [2];
  logic [1:0] occ_q;
  logic [1:0] occ_next;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       rd_ptr_next;
  frame_t     head;
  logic [MXCLUSTERS-1:0][MXCLBITS-1:0] head_words;

  // With both slots full the pointers coincide, so a same-cycle release frees exactly the write slot.
  assign wr_accept = wr_req && (!occ_q[wr_ptr] || (rel && (rd_ptr == wr_ptr)));

  always_comb begin
    occ_next = occ_q;
    if (rel)       occ_next[rd_ptr] = 1'b0;
    if (wr_accept) occ_next[wr_ptr] = 1'b1;
  end

  assign rd_ptr_next     = rel ? ~rd_ptr : rd_ptr;
  assign head_valid_next = occ_next[rd_ptr_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      occ_q     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      if (wr_accept) begin
        slot_q[wr_ptr] <= wr_frame;
        wr_ptr         <= ~wr_ptr;
      end
      occ_q  <= occ_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  assign head       = slot_q[rd_ptr];
  assign head_words = head.clusters;
  assign rd_nsent   = head.nsent;

  always_comb begin
    rd_word = head_words[rd_idx];
    if (rd_hdr) rd_word = make_header(head.overflow, head.nsent, head.bx[HDR_BX_BITS-1:0]);
  end

endmodule

// File: rtl/cluster_frame_scheduler.sv
// Per-BX readout scheduler: snapshots clusters into a 2-deep store and serialises header + cluster
// words onto the output link, dropping and counting BXs that find the store full.
module cluster_frame_scheduler
  import cluster_frame_scheduler_pkg::*;
(
  input  logic                           clock4x,
  input  logic                           reset_n,
  input  logic                           bc0,
  input  logic                           bx_strobe,
  input  logic [MXCNTBITS-1:0]           cnt,
  input  logic                           overflow,
  input  logic [MXCLUSTERS*MXCLBITS-1:0] clusters_in,
  cluster_frame_scheduler_if.master      link,
  output logic                           drop,
  output logic [15:0]                    drop_cnt,
  output state_t                         state_dbg
);

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [BXBITS-1:0]   bx_q;
  logic [BXBITS-1:0]   bx_next;
  frame_t              wr_frame;
  logic                wr_accept;
  logic                head_valid_next;
  logic [NSBITS-1:0]   rd_nsent;
  logic [MXCLBITS-1:0] rd_word;
  state_t              state;
  logic [IDXBITS-1:0]  idx;
  logic                valid_q;
  logic                frame_q;
  logic                accept;
  logic                last_word;
  logic                rel;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // The frame is stamped with the BX number this strobe moves the counter to.
  assign bx_next = (bc0 || (bx_q == BXBITS'(BXMAX))) ? '0 : bx_q + 1'b1;

  always_ff @(posedge clock4x or negedge rst_n) begin
    if (!rst_n)         bx_q <= '0;
    else if (bx_strobe) bx_q <= bx_next;
  end

  always_comb begin
    wr_frame          = '0;
    wr_frame.bx       = bx_next;
    wr_frame.overflow = overflow;
    wr_frame.nsent    = clamp_nsent(cnt);
    wr_frame.clusters = clusters_in;
  end

  assign accept    = valid_q && link.link_ready;
  assign last_word = (NSBITS'(idx) + NSBITS'(1)) == rd_nsent;
  assign rel       = accept && (((state == ST_HDR) && (rd_nsent == '0)) ||
                                ((state == ST_CLU) && last_word));

  cluster_frame_scheduler_buffer u_buffer (
    .clk             (clock4x),
    .rst_n           (rst_n),
    .wr_req          (bx_strobe),
    .wr_frame        (wr_frame),
    .rel             (rel),
    .rd_hdr          (state == ST_HDR),
    .rd_idx          (idx),
    .wr_accept       (wr_accept),
    .head_valid_next (head_valid_next),
    .rd_nsent        (rd_nsent),
    .rd_word         (rd_word)
  );

  // head_valid_next already includes a capture on this edge, giving the one-cycle header latency.
  always_ff @(posedge clock4x or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (head_valid_next) begin
            state   <= ST_HDR;
            valid_q <= 1'b1;
            frame_q <= 1'b1;
          end
        end
        ST_HDR: begin
          if (accept) begin
            if (rd_nsent != '0) begin
              state   <= ST_CLU;
              idx     <= '0;
              frame_q <= 1'b0;
            end else if (!head_valid_next) begin
              state   <= ST_IDLE;
              valid_q <= 1'b0;
              frame_q <= 1'b0;
            end
          end
        end
        ST_CLU: begin
          if (accept) begin
            if (!last_word) begin
              idx <= idx + 1'b1;
            end else if (head_valid_next) begin
              state   <= ST_HDR;
              frame_q <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          frame_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock4x or negedge rst_n) begin
    if (!rst_n) begin
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= bx_strobe && !wr_accept;
      if (bx_strobe && !wr_accept && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign link.link_valid = valid_q;
  assign link.link_frame = frame_q;
  assign link.link_data  = valid_q ? rd_word : '0;
  assign state_dbg       = state;

endmodule
